load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ACCESS_WAIT, default 0: extra wait cycles per memory access (legal range 0..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  upstream request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_addr  input  4  word address.
REQ-008 SHALL have port req_wdata  input  8  store data.
REQ-009 SHALL have port rsp_valid  output  1  response present.
REQ-010 SHALL have port rsp_ready  input  1  downstream accepts response.
REQ-011 SHALL have port rsp_rdata  output  8  load data, or echoed store data.
REQ-012 SHALL have port mem_en  output  1  to data memory Enable.
REQ-013 SHALL have port mem_we  output  1  to data memory WEnable.
REQ-014 SHALL have port mem_addr  output  4  to data memory Address.
REQ-015 SHALL have port mem_wdata  output  8  to data memory In.
REQ-016 SHALL have port mem_rdata  input  8  from data memory Out; combinational read, valid in the same cycle as mem_en/mem_addr.
REQ-017 SHALL have port acc_count  output  8  completed-transaction count, saturating.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-019 IDLE: req_ready=1, mem_en=0, mem_we=0; on req_valid=1 latch req_we/req_addr/req_wdata, load wait counter with ACCESS_WAIT, go to ACCESS.
REQ-020 ACCESS: req_ready=0, mem_en=1, mem_addr=latched addr, mem_wdata=latched wdata; decrement wait counter each cycle while nonzero.
REQ-021 mem_we SHALL be 1 only in the final ACCESS cycle (counter==0) of a store, giving exactly one memory write edge per store.
REQ-022 In the final ACCESS cycle: load captures mem_rdata into rsp_rdata; store copies latched wdata into rsp_rdata; go to RESP.
REQ-023 RESP: rsp_valid=1, mem_en=0, req_ready=0; rsp_rdata stable until handshake; on rsp_ready=1 increment acc_count (hold at 255) and go to IDLE.
REQ-024 Latency with ACCESS_WAIT=0: request accepted at edge N, ACCESS during cycle N..N+1, rsp_valid high from edge N+1; general: rsp_valid rises ACCESS_WAIT+1 edges after acceptance.
REQ-025 Throughput SHALL be one transaction per ACCESS_WAIT+3 cycles minimum; no request accepted while ACCESS or RESP.
REQ-026 req_valid deasserted or inputs changed after acceptance SHALL NOT affect the in-flight transaction.
REQ-027 rsp_valid held with rsp_ready=0 SHALL stall indefinitely without re-accessing memory.
REQ-028 Address 15 and address 0 SHALL be handled identically to others; no wrap or increment logic.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, rsp_valid=0, rsp_rdata=0, acc_count=0, wait counter=0, latched op/addr/wdata=0.
REQ-030 Reset during ACCESS SHALL abort the transaction: mem_we=0 from the following cycle, no response, no count increment; a write already clocked remains.
REQ-031 While rst=1, req_ready SHALL be 0; mem_en and mem_we SHALL be 0.

Structure
REQ-032 State encoding, ADDR_W=4, DATA_W=8 SHALL live in a shared microcontroller package.
REQ-033 The wait counter SHALL be a sub-module named wait_counter (load, decrement, zero flag).
REQ-034 No sub-memory SHALL be instantiated; the unit connects to the existing data memory externally.

Verification
REQ-035 Store addr 3 data 0xA5, then load addr 3 -> single mem_we pulse at addr 3; load rsp_rdata=0xA5; acc_count=2.
REQ-036 ACCESS_WAIT=2, load addr 7 -> mem_en high 3 cycles, rsp_valid 3 edges after acceptance.
REQ-037 rsp_ready=0 for 5 cycles during RESP -> rsp_valid and rsp_rdata held, req_ready=0, mem_en=0 throughout.
REQ-038 rst asserted in ACCESS of store to addr 9 (ACCESS_WAIT=2, before final cycle) -> no write to addr 9, rsp_valid=0, acc_count=0.
REQ-039 300 back-to-back transactions -> acc_count saturates at 255.
REQ-040 Change req_addr/req_wdata the cycle after acceptance -> memory sees original values.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// load_store_unit_pkg
// Shared microcontroller definitions for the load/store unit: bus widths,
// the LSU state encoding and a saturating counter helper.
// ---------------------------------------------------------------------------
package load_store_unit_pkg;

  localparam int ADDR_W = 4;   // word address width
  localparam int DATA_W = 8;   // data word width
  localparam int CNT_W  = 4;   // wait counter width (ACCESS_WAIT 0..15)
  localparam int ACC_W  = 8;   // completed-transaction counter width

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [ACC_W-1:0] sat_inc(input logic [ACC_W-1:0] v);
    if (v == {ACC_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(ACC_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Request / response handshake and data-memory bus of the load/store unit.
//   slave  : the load/store unit side
//   master : the environment side (upstream requester, downstream consumer,
//            and the external data memory)
// ---------------------------------------------------------------------------
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  // upstream request
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  // downstream response
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  // data memory (combinational read)
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/load_store_unit_wait_counter.sv
// ---------------------------------------------------------------------------
// wait_counter
// Down-counter for the per-access wait states of the load/store unit.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears the count)
//   load_i        : load load_val_i (priority over decrement)
//   load_val_i    : value to load
//   dec_i         : decrement request; ignored once the count is zero
//   zero_o        : count is zero (final access cycle)
// ---------------------------------------------------------------------------
module wait_counter
  import load_store_unit_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  // Load / saturating-at-zero decrement of the wait count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {W{1'b0}};
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != {W{1'b0}})) begin
      count_q <= count_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_q <= count_q;
    end
  end

  assign zero_o = (count_q == {W{1'b0}});

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Single-outstanding load/store engine sitting between an upstream
// requester and the external data memory.  A request is latched in IDLE,
// the memory is accessed for ACCESS_WAIT+1 cycles (write strobe only in the
// last one), and the result is held in RESP until the consumer takes it.
// Parameters:
//   ACCESS_WAIT : extra wait cycles per memory access, legal range 0..15
// Ports:
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : request/response handshake + data memory bus (slave side)
//   acc_count  : completed-transaction count, saturates at 255
// ---------------------------------------------------------------------------
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ACCESS_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus,
  output logic [ACC_W-1:0]  acc_count
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(ACCESS_WAIT);

  lsu_state_e        state_q;
  logic              op_we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ACC_W-1:0]  acc_count_q;
  logic [ACC_W-1:0]  acc_count_d;

  logic accept_s;
  logic in_access_s;
  logic wait_zero_s;

  assign accept_s    = (state_q == ST_IDLE) && bus.req_valid;
  assign in_access_s = (state_q == ST_ACCESS);
  assign acc_count_d = sat_inc(acc_count_q);

  wait_counter #(
    .W (CNT_W)
  ) u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept_s),
    .load_val_i (WAIT_INIT),
    .dec_i      (in_access_s),
    .zero_o     (wait_zero_s)
  );

  // Transaction FSM: latch request, capture response data, count completions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_we_q     <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      rdata_q     <= {DATA_W{1'b0}};
      acc_count_q <= {ACC_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            // Everything the access needs is captured here, so upstream may
            // drop or change its inputs from the next cycle on.
            op_we_q <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            state_q <= ST_ACCESS;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (wait_zero_s) begin
            // Stores echo their own data back as the response.
            rdata_q <= op_we_q ? wdata_q : bus.mem_rdata;
            state_q <= ST_RESP;
          end else begin
            state_q <= ST_ACCESS;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            acc_count_q <= acc_count_d;
            state_q     <= ST_IDLE;
          end else begin
            state_q <= ST_RESP;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are a pure decode of registered state.  The handshake and memory
  // strobes are additionally masked by rst so nothing is offered or written
  // in a cycle where reset is pending.
  assign bus.req_ready = !rst && (state_q == ST_IDLE);
  assign bus.mem_en    = !rst && in_access_s;
  assign bus.mem_we    = !rst && in_access_s && op_we_q && wait_zero_s;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign acc_count     = acc_count_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sel;          // 0: DUT with ACCESS_WAIT=0, 1: DUT with ACCESS_WAIT=2
  logic       req_valid;
  logic       req_we;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_ready;
  logic [7:0] acc0, acc2;

  load_store_unit_if b0 ();
  load_store_unit_if b2 ();

  load_store_unit #(.ACCESS_WAIT(0)) dut0 (.clk(clk), .rst(rst), .bus(b0), .acc_count(acc0));
  load_store_unit #(.ACCESS_WAIT(2)) dut2 (.clk(clk), .rst(rst), .bus(b2), .acc_count(acc2));

  assign b0.req_valid = req_valid & ~sel;
  assign b2.req_valid = req_valid & sel;
  assign b0.rsp_ready = rsp_ready & ~sel;
  assign b2.rsp_ready = rsp_ready & sel;
  assign b0.req_we    = req_we;
  assign b2.req_we    = req_we;
  assign b0.req_addr  = req_addr;
  assign b2.req_addr  = req_addr;
  assign b0.req_wdata = req_wdata;
  assign b2.req_wdata = req_wdata;

  // external data memory with write monitor
  logic [7:0] mem [16];
  int         wr_total;
  int         en_total;
  int         wr_cnt [16];
  logic [3:0] last_wr_addr;
  logic [7:0] last_wr_data;

  assign b0.mem_rdata = mem[b0.mem_addr];
  assign b2.mem_rdata = mem[b2.mem_addr];

  always @(posedge clk) begin
    if (b0.mem_en && b0.mem_we) begin
      mem[b0.mem_addr]    <= b0.mem_wdata;
      wr_total            <= wr_total + 1;
      wr_cnt[b0.mem_addr] <= wr_cnt[b0.mem_addr] + 1;
      last_wr_addr        <= b0.mem_addr;
      last_wr_data        <= b0.mem_wdata;
    end else if (b2.mem_en && b2.mem_we) begin
      mem[b2.mem_addr]    <= b2.mem_wdata;
      wr_total            <= wr_total + 1;
      wr_cnt[b2.mem_addr] <= wr_cnt[b2.mem_addr] + 1;
      last_wr_addr        <= b2.mem_addr;
      last_wr_data        <= b2.mem_wdata;
    end
    if (b0.mem_en || b2.mem_en) en_total <= en_total + 1;
  end

  // observation of the selected DUT
  logic       rsp_valid_m, req_ready_m, mem_en_m, mem_we_m;
  logic [7:0] rsp_rdata_m, acc_m;
  assign rsp_valid_m = sel ? b2.rsp_valid : b0.rsp_valid;
  assign req_ready_m = sel ? b2.req_ready : b0.req_ready;
  assign mem_en_m    = sel ? b2.mem_en    : b0.mem_en;
  assign mem_we_m    = sel ? b2.mem_we    : b0.mem_we;
  assign rsp_rdata_m = sel ? b2.rsp_rdata : b0.rsp_rdata;
  assign acc_m       = sel ? acc2         : acc0;

  int         total = 0;
  int         bad = 0;
  logic [7:0] ref_mem [16];
  int         exp_acc [2];
  logic [7:0] exp_q [$];

  task automatic do_txn(input logic s, input logic we, input logic [3:0] a,
                        input logic [7:0] d, input int stall);
    int         w, lat, en0, wr0, guard;
    logic [7:0] exp_v, held, got_v;
    w = s ? 2 : 0;
    sel = s; req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; rsp_ready = 1'b0;
    guard = 0;
    while (!req_ready_m && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (!req_ready_m) begin
      bad++;
      $display("FAIL accept_timeout: req_ready=%b required 1", req_ready_m);
      req_valid = 1'b0;
      return;
    end
    en0 = en_total; wr0 = wr_total;
    exp_v = we ? d : ref_mem[a];
    if (we) ref_mem[a] = d;
    exp_q.push_back(exp_v);
    @(negedge clk);
    // scramble the request inputs right after acceptance
    req_valid = 1'b0; req_addr = ~a; req_wdata = ~d; req_we = ~we;
    lat = 1;
    while (!rsp_valid_m && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (!rsp_valid_m || lat != w + 2) begin
      bad++;
      $display("FAIL latency: rsp_valid=%b after %0d edges, required 1 after %0d", rsp_valid_m, lat - 1, w + 1);
    end
    if (!rsp_valid_m) begin
      void'(exp_q.pop_front());
      return;
    end
    total++;
    if (en_total - en0 != w + 1) begin
      bad++;
      $display("FAIL mem_en_cycles: got %0d required %0d", en_total - en0, w + 1);
    end
    total++;
    if (wr_total - wr0 != (we ? 1 : 0)) begin
      bad++;
      $display("FAIL write_count: got %0d required %0d", wr_total - wr0, we ? 1 : 0);
    end
    if (we) begin
      total++;
      if (last_wr_addr !== a || last_wr_data !== d) begin
        bad++;
        $display("FAIL write_target: got addr %0d data %02h required addr %0d data %02h", last_wr_addr, last_wr_data, a, d);
      end
    end
    held = rsp_rdata_m;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid_m !== 1'b1 || rsp_rdata_m !== held || req_ready_m !== 1'b0 || mem_en_m !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold: valid=%b rdata=%02h ready=%b mem_en=%b required 1 %02h 0 0", rsp_valid_m, rsp_rdata_m, req_ready_m, mem_en_m, held);
      end
    end
    got_v = rsp_rdata_m;
    exp_v = exp_q.pop_front();
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL rsp_rdata: got %02h required %02h (addr %0d we %b)", got_v, exp_v, a, we);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (exp_acc[s] < 255) exp_acc[s] = exp_acc[s] + 1;
    total++;
    if (acc_m !== 8'(exp_acc[s]) || rsp_valid_m !== 1'b0 || req_ready_m !== 1'b1) begin
      bad++;
      $display("FAIL complete: acc=%0d valid=%b ready=%b required %0d 0 1", acc_m, rsp_valid_m, req_ready_m, exp_acc[s]);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd1; req_wdata = 8'h11; rsp_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (b0.req_ready !== 1'b0 || b2.req_ready !== 1'b0 || b0.mem_en !== 1'b0 || b2.mem_en !== 1'b0 ||
        b0.mem_we !== 1'b0 || b2.mem_we !== 1'b0) begin
      bad++;
      $display("FAIL reset_strobes: ready=%b%b en=%b%b we=%b%b required all 0", b0.req_ready, b2.req_ready, b0.mem_en, b2.mem_en, b0.mem_we, b2.mem_we);
    end
    total++;
    if (b0.rsp_valid !== 1'b0 || b2.rsp_valid !== 1'b0 || b0.rsp_rdata !== 8'h00 || b2.rsp_rdata !== 8'h00 ||
        acc0 !== 8'd0 || acc2 !== 8'd0) begin
      bad++;
      $display("FAIL reset_state: valid=%b%b rdata=%02h/%02h acc=%0d/%0d required 0", b0.rsp_valid, b2.rsp_valid, b0.rsp_rdata, b2.rsp_rdata, acc0, acc2);
    end
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (b0.req_ready !== 1'b1 || b2.req_ready !== 1'b1 || wr_total != 0) begin
      bad++;
      $display("FAIL reset_release: ready=%b%b writes=%0d required 11 0", b0.req_ready, b2.req_ready, wr_total);
    end
    exp_acc[0] = 0; exp_acc[1] = 0;
  endtask

  task automatic test_store_load();
    int w3;
    w3 = wr_cnt[3];
    do_txn(1'b0, 1'b1, 4'd3, 8'hA5, 0);
    do_txn(1'b0, 1'b0, 4'd3, 8'h00, 0);
    total++;
    if (wr_cnt[3] - w3 != 1 || acc0 !== 8'd2) begin
      bad++;
      $display("FAIL store_load: writes@3=%0d acc=%0d required 1 2", wr_cnt[3] - w3, acc0);
    end
  endtask

  task automatic test_fill();
    logic [7:0] v;
    for (int i = 0; i < 16; i++) begin
      v = 8'(i * 17) ^ 8'h5A;
      do_txn(1'b0, 1'b1, 4'(i), v, 0);
    end
    // boundary addresses read back
    do_txn(1'b0, 1'b0, 4'd0, 8'h00, 0);
    do_txn(1'b0, 1'b0, 4'd15, 8'h00, 0);
  endtask

  task automatic test_wait2();
    do_txn(1'b1, 1'b0, 4'd7, 8'h00, 0);
    do_txn(1'b1, 1'b1, 4'd15, 8'h3E, 0);
    do_txn(1'b1, 1'b0, 4'd15, 8'h00, 1);
  endtask

  task automatic test_stall();
    do_txn(1'b0, 1'b0, 4'd3, 8'h00, 5);
    do_txn(1'b1, 1'b1, 4'd2, 8'h77, 5);
  endtask

  task automatic test_reset_access();
    int w9;
    w9 = wr_cnt[9];
    sel = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd9; req_wdata = 8'h3C; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (mem_en_m !== 1'b1 || mem_we_m !== 1'b0) begin
      bad++;
      $display("FAIL abort_setup: mem_en=%b mem_we=%b required 1 0", mem_en_m, mem_we_m);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid_m !== 1'b0 || mem_en_m !== 1'b0 || mem_we_m !== 1'b0) begin
        bad++;
        $display("FAIL abort_idle: valid=%b en=%b we=%b required 0 0 0", rsp_valid_m, mem_en_m, mem_we_m);
      end
    end
    rsp_ready = 1'b0;
    exp_acc[0] = 0; exp_acc[1] = 0;
    total++;
    if (wr_cnt[9] != w9 || acc2 !== 8'd0) begin
      bad++;
      $display("FAIL abort_effect: writes@9=%0d acc=%0d required 0 0", wr_cnt[9] - w9, acc2);
    end
    do_txn(1'b1, 1'b0, 4'd9, 8'h00, 0);
  endtask

  task automatic test_back_to_back();
    logic       we;
    logic [3:0] a;
    logic [7:0] d;
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      d  = 8'($urandom);
      do_txn(1'b0, we, a, d, 0);
    end
    total++;
    if (acc0 !== 8'd255) begin
      bad++;
      $display("FAIL saturate: acc=%0d required 255", acc0);
    end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = 4'd0; req_wdata = 8'h00; rsp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_fill();
    test_wait2();
    test_stall();
    test_reset_access();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
